// File: rtl/divide_unit.sv
// divide_unit: iterative RV32M divider (DIV/DIVU/REM/REMU) with a restoring
// radix-2 datapath, one quotient bit per cycle, and single-cycle fast paths
// for divide-by-zero and signed overflow.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; accepts operands on the start edge
// CALC  | one restoring shift/subtract step per edge
// FIXUP | apply signs and select quotient or remainder into result
// DONE  | done pulse; result/dest_reg_out valid for writeback
module divide_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            funct,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [4:0]            dest_reg_in,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            dest_reg_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] C_ZERO    = '0;
    localparam logic [DATA_WIDTH-1:0] C_ONES    = '1;
    localparam logic [DATA_WIDTH-1:0] C_MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  C_LAST    = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [1:0]              r_funct;
    logic [4:0]              r_dest;
    logic                    r_sign_a;
    logic                    r_sign_b;
    logic [DATA_WIDTH-1:0]   r_bmag;
    logic [DATA_WIDTH-1:0]   r_rem;
    logic [DATA_WIDTH-1:0]   r_quo;
    logic [DATA_WIDTH-1:0]   r_result;

    // funct[0]=0 selects the signed variants (DIV/REM)
    logic                    w_signed;
    logic                    w_sign_a;
    logic                    w_sign_b;
    logic [DATA_WIDTH-1:0]   w_amag;
    logic [DATA_WIDTH-1:0]   w_bmag;
    logic                    w_div_zero;
    logic                    w_overflow;
    logic [DATA_WIDTH:0]     w_shift;
    logic [DATA_WIDTH:0]     w_diff;
    logic                    w_fits;
    logic [DATA_WIDTH-1:0]   w_quo_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;

    assign w_signed   = ~funct[0];
    assign w_sign_a   = w_signed & operand_a[DATA_WIDTH-1];
    assign w_sign_b   = w_signed & operand_b[DATA_WIDTH-1];
    assign w_amag     = w_sign_a ? (C_ZERO - operand_a) : operand_a;
    assign w_bmag     = w_sign_b ? (C_ZERO - operand_b) : operand_b;
    assign w_div_zero = (operand_b == C_ZERO);
    assign w_overflow = w_signed & (operand_a == C_MIN_NEG) & (operand_b == C_ONES);

    // Remainder is always below |b|, so the shifted value fits in DATA_WIDTH+1
    // bits and the difference MSB is a clean borrow flag.
    assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_bmag};
    assign w_fits     = ~w_diff[DATA_WIDTH];

    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (C_ZERO - r_quo) : r_quo;
    assign w_rem_fix  = r_sign_a ? (C_ZERO - r_rem) : r_rem;

    assign busy         = (r_state == S_CALC) | (r_state == S_FIXUP);
    assign done         = (r_state == S_DONE);
    assign stall        = ((r_state == S_IDLE) & start) | busy;
    assign result       = r_result;
    assign dest_reg_out = r_dest;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (w_div_zero | w_overflow) ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == C_LAST) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, restoring iteration and result registration
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_funct  <= '0;
            r_dest   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_bmag   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct  <= funct;
                        r_dest   <= dest_reg_in;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_bmag   <= w_bmag;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_amag;
                        if (w_div_zero)
                            r_result <= funct[1] ? operand_a : C_ONES;
                        else if (w_overflow)
                            r_result <= funct[1] ? C_ZERO : C_MIN_NEG;
                    end
                end
                S_CALC: begin
                    r_rem <= w_fits ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_quo <= {r_quo[DATA_WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIXUP: begin
                    r_result <= r_funct[1] ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_unit.sv
// Directed testbench for divide_unit: hand-computed vectors, latency and
// control-signal checks, reset abort and start-while-busy behaviour.
module tb_divide_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg_in;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  dest_reg_out;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    divide_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_reg_in (dest_reg_in),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dest_reg_out(dest_reg_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(output int n, output bit busy_seen);
        n = 0;
        busy_seen = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_seen = 1'b1;
            @(negedge clock);
            n++;
        end
    endtask

    // Called at a negedge; returns at a later negedge with the unit back in IDLE.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp_res, input int exp_lat);
        int  n;
        bit  bs;
        funct       = f;
        operand_a   = a;
        operand_b   = b;
        dest_reg_in = d;
        start       = 1'b1;
        #1;
        chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0000_0001;
        wait_done(n, bs);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_dest"}, {27'd0, dest_reg_out}, {27'd0, d});
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_busy_seen"}, {31'd0, bs}, (exp_lat != 0) ? 32'd1 : 32'd0);
        @(negedge clock);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        int  n;
        bit  bs;
        bit  seen;

        reset       = 1'b1;
        start       = 1'b0;
        funct       = 2'b00;
        operand_a   = '0;
        operand_b   = '0;
        dest_reg_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_dest",   {27'd0, dest_reg_out}, 32'd0);
        chk("rst_ctrl",   {29'd0, done, busy, stall}, 32'd0);

        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
        run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2",   F_DIV,  32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",   F_REM,  32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, 33);
        run_op("divu_123_0", F_DIVU, 32'd123, 32'd0, 5'd14, 32'hFFFF_FFFF, 0);
        run_op("remu_123_0", F_REMU, 32'd123, 32'd0, 5'd15, 32'd123, 0);
        run_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0);
        run_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 0);
        run_op("divu_big",   F_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd18, 32'h0FFF_FFFF, 33);

        // Reset during CALC after ten iterations
        funct       = F_DIVU;
        operand_a   = 32'd100;
        operand_b   = 32'd7;
        dest_reg_in = 5'd20;
        start       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_ctrl",   {29'd0, done, busy, stall}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_dest",   {27'd0, dest_reg_out}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 33);

        // Start pulsed and then held during CALC; first op must be unaffected
        funct       = F_DIVU;
        operand_a   = 32'd1000;
        operand_b   = 32'd10;
        dest_reg_in = 5'd7;
        start       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        funct       = F_REMU;
        operand_a   = 32'd50;
        operand_b   = 32'd3;
        dest_reg_in = 5'd3;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        funct       = F_DIVU;
        operand_a   = 32'd77;
        operand_b   = 32'd7;
        dest_reg_in = 5'd9;
        start       = 1'b1;
        wait_done(n, bs);
        chk("held_first_latency", n + 11, 33);
        chk("held_first_result", result, 32'd100);
        chk("held_first_dest",   {27'd0, dest_reg_out}, 32'd7);
        chk("held_stall_done",   {31'd0, stall}, 32'd0);
        @(negedge clock);
        chk("held_idle_ctrl", {29'd0, done, busy, stall}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        operand_a = 32'd5;
        operand_b = 32'd5;
        chk("held_second_busy", {31'd0, busy}, 32'd1);
        wait_done(n, bs);
        chk("held_second_latency", n, 33);
        chk("held_second_result", result, 32'd11);
        chk("held_second_dest",   {27'd0, dest_reg_out}, 32'd9);
        @(negedge clock);
        chk("held_second_pulse", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
